// File: rtl/control_pkg.sv
// Shared opcode encodings, control-word layout and pipe state type for control_pipe.
package control_pkg;

  localparam logic [2:0] OP_LDI = 3'b000;
  localparam logic [2:0] OP_BR0 = 3'b011;
  localparam logic [2:0] OP_BR1 = 3'b101;
  localparam logic [2:0] OP_LD  = 3'b110;
  localparam logic [2:0] OP_ST  = 3'b111;

  typedef struct packed {
    logic branch;
    logic ld_immed;
    logic mem_to_reg;
    logic mem_write;
    logic reg_write;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_NOP = '0;
  localparam ctrl_word_t CTRL_DEFAULT = '{branch: 1'b0, ld_immed: 1'b0, mem_to_reg: 1'b1,
                                         mem_write: 1'b0, reg_write: 1'b1};

  typedef enum logic [1:0] {RUN, HOLD, FLUSH} state_t;

endpackage

// File: rtl/control_decode.sv
// Combinational opcode decoder: control word plus memory-op and illegal-opcode flags.
module control_decode
  import control_pkg::*;
#(
  parameter int OPW = 3
) (
  input  logic [OPW-1:0] op_i,
  output ctrl_word_t     word_o,
  output logic           is_mem_o,
  output logic           illegal_o
);

  logic [2:0] op3;
  logic       upper_set;

  assign op3 = op_i[2:0];

  generate
    if (OPW > 3) begin : g_wide
      assign upper_set = |op_i[OPW-1:3];
    end else begin : g_narrow
      assign upper_set = 1'b0;
    end
  endgenerate

  always_comb begin
    word_o    = CTRL_DEFAULT;
    is_mem_o  = 1'b0;
    illegal_o = upper_set;
    if (upper_set) begin
      word_o = CTRL_NOP;
    end else begin
      case (op3)
        OP_LDI:         word_o.ld_immed = 1'b1;
        OP_BR0, OP_BR1: word_o.branch = 1'b1;
        OP_ST: begin
          word_o.mem_write = 1'b1;
          word_o.reg_write = 1'b0;
          is_mem_o         = 1'b1;
        end
        OP_LD:          is_mem_o = 1'b1;
        default:        ;
      endcase
    end
  end

endmodule

// File: rtl/control_pipe.sv
// Registered control-word stage: valid/ready intake, LD/ST hold timer, taken-branch squash.
module control_pipe
  import control_pkg::*;
#(
  parameter int OPW     = 3,
  parameter int MEM_LAT = 2,
  parameter int CNTW    = 16
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [OPW-1:0]  op_i,
  input  logic            op_valid_i,
  output logic            op_ready_o,
  input  logic            br_taken_i,
  output logic            ctrl_valid_o,
  output logic            branch_o,
  output logic            ldImmed_o,
  output logic            MemtoReg_o,
  output logic            MemWrite_o,
  output logic            RegWrite_o,
  output logic            mem_busy_o,
  output logic            illegal_o,
  output logic [CNTW-1:0] issue_cnt_o
);

  localparam int HW = $clog2(MEM_LAT + 1);
  localparam logic [HW-1:0] HCNT_ONE = HW'(1);
  localparam logic [HW-1:0] HCNT_LAT = HW'(MEM_LAT);

  state_t          state_q, state_d;
  ctrl_word_t      word_q, word_d;
  logic            valid_q, valid_d;
  logic            illegal_q, illegal_d;
  logic            busy_q, busy_d;
  logic [HW-1:0]   hcnt_q, hcnt_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  ctrl_word_t dec_word;
  logic       dec_is_mem;
  logic       dec_illegal;
  logic       accept;
  logic       squash_now;

  control_decode #(.OPW(OPW)) u_decode (
    .op_i      (op_i),
    .word_o    (dec_word),
    .is_mem_o  (dec_is_mem),
    .illegal_o (dec_illegal)
  );

  assign op_ready_o = (hcnt_q <= HCNT_ONE);
  assign accept     = op_valid_i && op_ready_o;
  // Only a freshly issued branch word may consume br_taken_i.
  assign squash_now = valid_q && word_q.branch && br_taken_i;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= RUN;
      word_q    <= CTRL_NOP;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      busy_q    <= 1'b0;
      hcnt_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
      busy_q    <= busy_d;
      hcnt_q    <= hcnt_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    valid_d   = 1'b0;
    illegal_d = illegal_q;
    busy_d    = busy_q;
    hcnt_d    = hcnt_q;
    if (accept) begin
      if (squash_now || state_q == FLUSH) begin
        // The op fetched behind a taken branch is dropped and never counted.
        word_d    = CTRL_NOP;
        illegal_d = 1'b0;
        busy_d    = 1'b0;
        hcnt_d    = HCNT_ONE;
        state_d   = RUN;
      end else begin
        word_d    = dec_word;
        valid_d   = 1'b1;
        illegal_d = dec_illegal;
        busy_d    = dec_is_mem;
        hcnt_d    = dec_is_mem ? HCNT_LAT : HCNT_ONE;
        state_d   = (dec_is_mem && MEM_LAT > 1) ? HOLD : RUN;
      end
    end else if (hcnt_q > HCNT_ONE) begin
      hcnt_d = hcnt_q - HCNT_ONE;
    end else begin
      word_d    = CTRL_NOP;
      illegal_d = 1'b0;
      busy_d    = 1'b0;
      if (squash_now) begin
        state_d = FLUSH;
      end else if (state_q == HOLD) begin
        state_d = RUN;
      end
    end
    cnt_d = cnt_q + CNTW'(valid_d);
  end

  assign ctrl_valid_o = valid_q;
  assign branch_o     = word_q.branch;
  assign ldImmed_o    = word_q.ld_immed;
  assign MemtoReg_o   = word_q.mem_to_reg;
  assign MemWrite_o   = word_q.mem_write;
  assign RegWrite_o   = word_q.reg_write;
  assign mem_busy_o   = busy_q;
  assign illegal_o    = illegal_q;
  assign issue_cnt_o  = cnt_q;

endmodule

// File: tb/tb_control_pipe.sv
// Self-checking bench for control_pipe (OPW=4, MEM_LAT=3) against a cycle-level behavioural model.
module tb_control_pipe;

  localparam int OPW     = 4;
  localparam int MEM_LAT = 3;
  localparam int CNTW    = 16;

  logic            Clk = 1'b0;
  logic            Reset = 1'b1;
  logic [OPW-1:0]  op_i = '0;
  logic            op_valid_i = 1'b0;
  logic            br_taken_i = 1'b0;
  logic            op_ready_o, ctrl_valid_o, branch_o, ldImmed_o, MemtoReg_o;
  logic            MemWrite_o, RegWrite_o, mem_busy_o, illegal_o;
  logic [CNTW-1:0] issue_cnt_o;

  control_pipe #(.OPW(OPW), .MEM_LAT(MEM_LAT), .CNTW(CNTW)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .op_i         (op_i),
    .op_valid_i   (op_valid_i),
    .op_ready_o   (op_ready_o),
    .br_taken_i   (br_taken_i),
    .ctrl_valid_o (ctrl_valid_o),
    .branch_o     (branch_o),
    .ldImmed_o    (ldImmed_o),
    .MemtoReg_o   (MemtoReg_o),
    .MemWrite_o   (MemWrite_o),
    .RegWrite_o   (RegWrite_o),
    .mem_busy_o   (mem_busy_o),
    .illegal_o    (illegal_o),
    .issue_cnt_o  (issue_cnt_o)
  );

  always #5 Clk = ~Clk;

  int n_pass  = 0;
  int n_total = 0;

  // Model: word shown this cycle, its flags, how many more cycles it stays, pending squash.
  logic [4:0]      m_word;   // {branch, ldImmed, MemtoReg, MemWrite, RegWrite}
  logic            m_valid, m_ill, m_busy;
  logic [CNTW-1:0] m_cnt;
  int              m_left;
  bit              m_sq;

  wire [8:0] act_vec = {op_ready_o, ctrl_valid_o, branch_o, ldImmed_o, MemtoReg_o,
                        MemWrite_o, RegWrite_o, mem_busy_o, illegal_o};

  function automatic logic [4:0] ref_decode(int op);
    case (op)
      0:       return 5'b01101;
      3, 5:    return 5'b10101;
      7:       return 5'b00110;
      default: return 5'b00101;
    endcase
  endfunction

  function automatic logic [8:0] exp_vec();
    return {m_left == 0, m_valid, m_word, m_busy, m_ill};
  endfunction

  task automatic model_reset();
    m_word = '0; m_valid = 0; m_ill = 0; m_busy = 0; m_cnt = '0; m_left = 0; m_sq = 0;
  endtask

  task automatic model_edge(int op, bit v, bit br);
    bit acc, taken;
    acc   = v && (m_left == 0);
    taken = m_valid && m_word[4] && br;
    if (acc) begin
      if (taken || m_sq) begin
        m_word = '0; m_valid = 0; m_ill = 0; m_busy = 0; m_left = 0; m_sq = 0;
      end else if (op >= 8) begin
        m_word = '0; m_valid = 1; m_ill = 1; m_busy = 0; m_left = 0;
      end else begin
        m_word  = ref_decode(op);
        m_valid = 1;
        m_ill   = 0;
        m_busy  = (op == 6 || op == 7);
        m_left  = m_busy ? MEM_LAT - 1 : 0;
      end
    end else if (m_left > 0) begin
      m_left  = m_left - 1;
      m_valid = 0;
    end else begin
      m_word = '0; m_valid = 0; m_ill = 0; m_busy = 0;
      if (taken) m_sq = 1;
    end
    if (m_valid) m_cnt = m_cnt + 1'b1;
  endtask

  // Drive at negedge, advance model at the edge, return at the next negedge.
  task automatic cyc(int op, bit v, bit br);
    op_i       = op[OPW-1:0];
    op_valid_i = v;
    br_taken_i = br;
    @(posedge Clk);
    model_edge(op, v, br);
    @(negedge Clk);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    model_reset();
    repeat (2) @(negedge Clk);
    n_total++;
    if (act_vec !== 9'b1_0_00000_0_0)
      $display("FAIL reset_outputs: got %b expected %b", act_vec, 9'b100000000);
    else n_pass++;
    n_total++;
    if (issue_cnt_o !== '0) $display("FAIL reset_cnt: got %0d expected 0", issue_cnt_o);
    else n_pass++;
    Reset = 1'b0;
  endtask

  task automatic test_basic();
    int ops[3] = '{0, 3, 7};
    for (int i = 0; i < 3; i++) begin
      cyc(ops[i], 1, 0);
      n_total++;
      if (act_vec !== exp_vec())
        $display("FAIL basic_vec step %0d: got %b expected %b", i, act_vec, exp_vec());
      else n_pass++;
    end
    n_total++;
    if ({MemWrite_o, RegWrite_o, ctrl_valid_o} !== 3'b101)
      $display("FAIL basic_st_word: got %b expected 101", {MemWrite_o, RegWrite_o, ctrl_valid_o});
    else n_pass++;
    n_total++;
    if (issue_cnt_o !== 16'd3) $display("FAIL basic_cnt: got %0d expected 3", issue_cnt_o);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0);
      n_total++;
      if (act_vec !== exp_vec())
        $display("FAIL basic_drain step %0d: got %b expected %b", i, act_vec, exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_mem_b2b();
    int ops[7]  = '{6, 7, 7, 7, 0, 0, 0};
    bit vals[7] = '{1, 1, 1, 1, 0, 0, 0};
    int busy_n = 0, notready_n = 0, valid_n = 0;
    for (int i = 0; i < 7; i++) begin
      cyc(ops[i], vals[i], 0);
      n_total++;
      if (act_vec !== exp_vec())
        $display("FAIL mem_vec step %0d: got %b expected %b", i, act_vec, exp_vec());
      else n_pass++;
      if (i < 6) begin
        busy_n     += int'(mem_busy_o);
        notready_n += int'(!op_ready_o);
        valid_n    += int'(ctrl_valid_o);
      end
    end
    n_total++;
    if (busy_n != 6 || notready_n != 4 || valid_n != 2)
      $display("FAIL mem_counts: got busy=%0d notready=%0d valid=%0d expected 6/4/2",
               busy_n, notready_n, valid_n);
    else n_pass++;
  endtask

  task automatic test_branch_squash();
    logic [CNTW-1:0] c0;
    cyc(5, 1, 0);
    c0 = issue_cnt_o;
    cyc(0, 1, 1);
    n_total++;
    if (act_vec !== exp_vec() || ctrl_valid_o !== 1'b0 || ldImmed_o !== 1'b0)
      $display("FAIL squash_vec: got %b expected %b", act_vec, exp_vec());
    else n_pass++;
    n_total++;
    if (issue_cnt_o !== c0) $display("FAIL squash_cnt: got %0d expected %0d", issue_cnt_o, c0);
    else n_pass++;
    cyc(0, 1, 0);
    n_total++;
    if (act_vec !== exp_vec() || ldImmed_o !== 1'b1 || ctrl_valid_o !== 1'b1)
      $display("FAIL squash_after: got %b expected %b", act_vec, exp_vec());
    else n_pass++;
  endtask

  task automatic test_branch_deferred();
    cyc(5, 1, 0);
    cyc(0, 0, 1);
    n_total++;
    if (act_vec !== exp_vec() || ctrl_valid_o !== 1'b0)
      $display("FAIL defer_gap: got %b expected %b", act_vec, exp_vec());
    else n_pass++;
    cyc(0, 1, 0);
    n_total++;
    if (act_vec !== exp_vec() || ctrl_valid_o !== 1'b0 || ldImmed_o !== 1'b0)
      $display("FAIL defer_squash: got %b expected %b", act_vec, exp_vec());
    else n_pass++;
    cyc(0, 1, 0);
    n_total++;
    if (act_vec !== exp_vec() || ldImmed_o !== 1'b1)
      $display("FAIL defer_resume: got %b expected %b", act_vec, exp_vec());
    else n_pass++;
    n_total++;
    if (issue_cnt_o !== m_cnt) $display("FAIL defer_cnt: got %0d expected %0d", issue_cnt_o, m_cnt);
    else n_pass++;
  endtask

  task automatic test_illegal();
    cyc(8, 1, 0);
    n_total++;
    if (act_vec !== 9'b1_1_00000_0_1)
      $display("FAIL illegal_vec: got %b expected %b", act_vec, 9'b110000001);
    else n_pass++;
    cyc(0, 0, 0);
  endtask

  task automatic test_reset_mid_hold();
    cyc(6, 1, 0);
    #2 Reset = 1'b1;
    #1;
    model_reset();
    n_total++;
    if (act_vec !== 9'b1_0_00000_0_0 || issue_cnt_o !== '0)
      $display("FAIL midhold_reset: got %b cnt %0d expected %b cnt 0",
               act_vec, issue_cnt_o, 9'b100000000);
    else n_pass++;
    @(negedge Clk);
    Reset = 1'b0;
    cyc(0, 1, 0);
    n_total++;
    if (act_vec !== exp_vec() || ldImmed_o !== 1'b1 || issue_cnt_o !== 16'd1)
      $display("FAIL midhold_resume: got %b cnt %0d expected %b cnt 1",
               act_vec, issue_cnt_o, exp_vec());
    else n_pass++;
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 400; i++) begin
      int op;
      op = ($urandom_range(0, 7) == 0) ? int'($urandom_range(8, 15)) : int'($urandom_range(0, 7));
      cyc(op, $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1);
      n_total++;
      if (act_vec !== exp_vec() || issue_cnt_o !== m_cnt) begin
        if (bad < 10)
          $display("FAIL random cycle %0d: got %b cnt %0d expected %b cnt %0d",
                   i, act_vec, issue_cnt_o, exp_vec(), m_cnt);
        bad++;
      end else n_pass++;
    end
  endtask

  initial begin
    @(negedge Clk);
    test_reset();
    test_basic();
    test_mem_b2b();
    test_branch_squash();
    test_branch_deferred();
    test_illegal();
    test_reset_mid_hold();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
